onehot_decoder: RTL
===================

# onehot_decoder

Receiving end of the channel-select encoder link. Accepts one-hot channel words with a valid/ready handshake, checks each word is strictly one-hot, converts legal words to a binary channel index and buffers them in a 2-entry FIFO for the downstream consumer. Illegal words (zero or multiple bits set) are dropped and counted in a saturating error counter with a sticky error flag.

## Interface
- N_CH, 16, number of channels (one-hot input width); power of two, ≥ 2
- IDX_W, $clog2(N_CH) = 4, channel index width
- ERR_W, 8, error counter width
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset; asynchronous, active-high
- enable_i  input  1  block enable; low blocks input acceptance, output side keeps draining
- hot_one_i  input  N_CH  one-hot channel word from encoder
- valid_i  input  1  hot_one_i valid
- ready_o  output  1  decoder can accept a word this cycle
- ch_idx_o  output  IDX_W  binary index of FIFO head
- ch_valid_o  output  1  FIFO head valid
- ch_ready_i  input  1  consumer accepts the head this cycle
- err_o  output  1  sticky illegal-word flag
- err_cnt_o  output  ERR_W  saturating illegal-word count
- clr_err_i  input  1  synchronous clear of err_o and err_cnt_o

## Operation
- Accept = valid_i && ready_o. ready_o = enable_i && !rst_i && (count != 2); combinational from registered count, no path from ch_ready_i.
- Classification of accepted word: legal iff popcount(hot_one_i) == 1; index = position of the set bit (bit 0 -> 0, bit 15 -> 15).
- Legal accepted word: pushed into FIFO as IDX_W-bit index.
- Illegal accepted word (0 bits or ≥2 bits): not pushed; err_o set; err_cnt_o += 1, saturating at 2^ERR_W−1.
- Pop = ch_valid_o && ch_ready_i; ch_idx_o/ch_valid_o present the head directly from registers.
- FIFO states (by count): EMPTY(0), ONE(1), FULL(2).
  - EMPTY: legal push -> ONE; otherwise stay.
  - ONE: push only -> FULL; pop only -> EMPTY; push+pop same cycle -> ONE (head replaced by new word); neither -> ONE.
  - FULL: ready_o low, no push; pop -> ONE (second entry becomes head).
- Order is strictly preserved; no entry is ever lost or duplicated.
- clr_err_i: err_o <= 0, err_cnt_o <= 0. If an illegal word is accepted in the same cycle, the new event wins: err_o <= 1, err_cnt_o <= 1.
- enable_i low: no acceptance; FIFO contents and error state retained; pops continue.
- ch_idx_o is held at the last head value when ch_valid_o is low (don't-care for checking, but must not be X after reset).

## Timing
- Reset (asynchronous, immediate): count = 0 (EMPTY), ch_valid_o = 0, ch_idx_o = 0, err_o = 0, err_cnt_o = 0, ready_o = 0 while rst_i high.
- Reset mid-operation discards all FIFO contents and error state; ready_o returns to 1 in the first cycle rst_i is low (if enable_i high).
- Latency: word accepted at edge k appears as ch_valid_o = 1 with its index after edge k when FIFO was EMPTY, or after the pop of the preceding entry otherwise.
- Throughput: one word per cycle sustained while ch_ready_i is held high (ONE state with push+pop every cycle).
- err_o/err_cnt_o update at the edge the illegal word is accepted.

## Test plan
- Reset, enable_i = 1, ch_ready_i = 1, drive 0x0001, 0x0040, 0x8000 on consecutive cycles -> ch_idx_o = 0, 6, 15 on the following three cycles, ch_valid_o high for each, err_o = 0.
- Drive 0x0022, 0x0000, 0xF040 -> no output entries; err_o = 1, err_cnt_o = 3; then pulse clr_err_i alone -> err_o = 0, err_cnt_o = 0.
- ch_ready_i = 0, drive 0x0004 continuously -> two entries (idx 2) stored, ready_o drops to 0 after the second accept; raise ch_ready_i -> exactly two idx-2 outputs, ready_o returns high the cycle after the first pop.
- ERR_W = 8: drive 300 illegal words -> err_cnt_o saturates at 255; clr_err_i asserted in same cycle as an illegal word -> err_cnt_o = 1, err_o = 1.
- Fill FIFO with idx 3 and 5, assert rst_i mid-cycle -> ch_valid_o, count, err state cleared immediately; after release first accepted 0x0400 yields idx 10 only.
- enable_i = 0 with valid_i high and one entry queued -> ready_o = 0, no accepts, queued entry still pops when ch_ready_i = 1.

Source files
------------

// File: rtl/onehot_decoder.sv
// onehot_decoder
//   Receiving end of the channel-select link. Accepts one-hot channel words
//   over a valid/ready handshake and checks that each word has exactly one bit
//   set. A legal word is turned into its binary channel index and queued in a
//   2-entry FIFO. An illegal word (no bits set, or more than one) is dropped.
//   Each dropped word sets a sticky flag and increments a saturating counter.
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   enable_i    low blocks input acceptance; the output side keeps draining
//   hot_one_i   one-hot channel word      valid_i / ready_o  input handshake
//   ch_idx_o    index at the FIFO head    ch_valid_o / ch_ready_i  output handshake
//   err_o       sticky illegal-word flag  err_cnt_o  saturating illegal count
//   clr_err_i   synchronous clear of err_o / err_cnt_o (a new illegal word wins)
//
// FIFO state (one state per occupancy):
//   state | meaning
//   EMPTY | no entries, ch_valid_o low
//   ONE   | head_q valid
//   FULL  | head_q and tail_q valid, ready_o low
module onehot_decoder #(
  parameter int N_CH  = 16,
  parameter int IDX_W = $clog2(N_CH),
  parameter int ERR_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [N_CH-1:0]  hot_one_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [IDX_W-1:0] ch_idx_o,
  output logic             ch_valid_o,
  input  logic             ch_ready_i,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  input  logic             clr_err_i
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t           state_q, state_d;
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [ERR_W-1:0] err_cnt_q;
  logic             err_q;

  logic             accept;
  logic             legal;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] word_idx;

  // Input handshake. The ready signal depends only on the registered state,
  // so there is no combinational path from ch_ready_i.
  assign ready_o = enable_i && !rst_i && (state_q != FULL);
  assign accept  = valid_i && ready_o;

  // A word is one-hot when it is nonzero and clearing its lowest set bit
  // leaves zero.
  assign legal = (hot_one_i != '0) &&
                 ((hot_one_i & (hot_one_i - N_CH'(1))) == '0);

  always_comb begin
    word_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (hot_one_i[i]) word_idx = IDX_W'(i);
    end
  end

  assign push = accept && legal;
  assign pop  = ch_valid_o && ch_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = word_idx;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          // The head leaves and the new word takes its place.
          head_d = word_idx;
        end else if (push) begin
          tail_d  = word_idx;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign ch_valid_o = (state_q != EMPTY);
  assign ch_idx_o   = head_q;

  // If a clear and an illegal word arrive in the same cycle, the illegal
  // word wins: the count restarts at 1 instead of going to 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (accept && !legal) begin
      err_q <= 1'b1;
      if (clr_err_i)
        err_cnt_q <= ERR_W'(1);
      else if (err_cnt_q != ERR_MAX)
        err_cnt_q <= err_cnt_q + ERR_W'(1);
    end else if (clr_err_i) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end
  end

  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule
